delay_line_checker: RTL

- Response-side companion to the team's `delay_line` block.
- Sits beside a `delay_line` instance, snooping the same `ce`/`idata` and the line's `odata`.
- Keeps its own reference copy of the input history and flags every cycle where `odata` differs from `idata` delayed by DELAY enabled edges.
- Used as a synthesizable self-check in lab designs and as the scoreboard in benches.

---
 rtl/delay_line_pkg.sv | 22 ++
 rtl/ref_shift_pipe.sv | 28 ++
 rtl/delay_line_checker.sv | 114 +++++++++++
 3 files changed

// File: rtl/delay_line_pkg.sv
// Shared definitions for the delay_line checker family: checker states,
// depth limit and the saturating counter helper.
package delay_line_pkg;

  localparam int unsigned DELAY_MAX = 64;
  // Wide enough to hold 0..DELAY_MAX
  localparam int unsigned FILL_W    = $clog2(DELAY_MAX + 1);

  // Checker states
  typedef logic [1:0] chk_state_t;
  localparam chk_state_t ST_FILL  = 2'd0;
  localparam chk_state_t ST_CHECK = 2'd1;
  localparam chk_state_t ST_FAIL  = 2'd2;

  // Increment val, sticking at 2^width-1 instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ref_shift_pipe.sv
// ce-gated shift register, structurally identical to the line under test.
// Doubles as a golden model of delay_line in benches.
module ref_shift_pipe #(
  parameter int unsigned N     = 4,
  parameter int unsigned DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] stage_q [DELAY];

  // Shift one stage per enabled edge; hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DELAY; k++) stage_q[k] <= '0;
    end else if (ce) begin
      stage_q[0] <= din;
      for (int k = 1; k < DELAY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign dout = stage_q[DELAY-1];

endmodule

// File: rtl/delay_line_checker.sv
// Response-side checker for delay_line: rebuilds the expected output from the
// snooped ce/idata and flags every cycle where odata disagrees.
// Optional: define DELAY_LINE_CHECKER_CAPTURE_EN to latch the first failing
// expected/observed pair and its compare index.
module delay_line_checker
  import delay_line_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned DELAY = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [N-1:0]     idata,
  input  logic [N-1:0]     odata,
`ifdef DELAY_LINE_CHECKER_CAPTURE_EN
  output logic [N-1:0]     exp_cap,
  output logic [N-1:0]     got_cap,
  output logic [CNT_W-1:0] cap_idx,
`endif
  output logic             armed,
  output logic             match,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] chk_count
);

  localparam logic [FILL_W-1:0] DELAY_L = FILL_W'(DELAY);

  logic [N-1:0]      exp_val;
  chk_state_t        state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              armed_q, match_q;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  chk_count_q, chk_count_d;
  logic              do_cmp, mismatch;

  ref_shift_pipe #(
    .N     (N),
    .DELAY (DELAY)
  ) u_ref (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .din  (idata),
    .dout (exp_val)
  );

  // Compare and next-state logic; all terms use pre-edge values
  always_comb begin
    do_cmp      = armed_q && (state_q != ST_FILL);
    // Case inequality so an X on odata counts as a mismatch in simulation
    mismatch    = do_cmp && (odata !== exp_val);
    fill_d      = (ce && (fill_q != DELAY_L)) ? fill_q + FILL_W'(1) : fill_q;
    chk_count_d = do_cmp ? CNT_W'(sat_inc(32'(chk_count_q), CNT_W)) : chk_count_q;
    err_count_d = mismatch ? CNT_W'(sat_inc(32'(err_count_q), CNT_W)) : err_count_q;
    state_d     = state_q;
    case (state_q)
      ST_FILL:  if (fill_d == DELAY_L) state_d = ST_CHECK;
      ST_CHECK: if (mismatch) state_d = ST_FAIL;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_FILL;
    endcase
  end

  // State, fill tracking, registered compare result and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FILL;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      match_q     <= 1'b1;
      err_count_q <= '0;
      chk_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      armed_q     <= (fill_d == DELAY_L);
      err_count_q <= err_count_d;
      chk_count_q <= chk_count_d;
      if (do_cmp) match_q <= !mismatch;
    end
  end

`ifdef DELAY_LINE_CHECKER_CAPTURE_EN
  logic [N-1:0]     exp_cap_q, got_cap_q;
  logic [CNT_W-1:0] cap_idx_q;

  // Latch the first mismatch only; cap_idx is the 1-based compare number
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_cap_q <= '0;
      got_cap_q <= '0;
      cap_idx_q <= '0;
    end else if (mismatch && (state_q == ST_CHECK)) begin
      exp_cap_q <= exp_val;
      got_cap_q <= odata;
      cap_idx_q <= chk_count_d;
    end
  end

  assign exp_cap = exp_cap_q;
  assign got_cap = got_cap_q;
  assign cap_idx = cap_idx_q;
`endif

  assign armed     = armed_q;
  assign match     = match_q;
  assign err       = (state_q == ST_FAIL);
  assign err_count = err_count_q;
  assign chk_count = chk_count_q;

endmodule
